// File: rtl/regfile_sb_reader.sv
// regfile_sb_reader: 32 x DW register file with a pending-write scoreboard on
// the decode read side. Two registered read ports (latency 1), one writeback
// port, one issue port that marks the destination register busy.
// Register 0 is hardwired to zero and is never busy.
// Optional build macro REGFILE_WB_BYPASS_EN: a source that matches the
// writeback in flight this cycle is not treated as a hazard and is captured
// straight from Wb_Data, removing one stall cycle per RAW dependency.
module regfile_sb_reader #(
  parameter int DW   = 32,
  parameter int NREG = 32,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          Rd_En,
  input  logic [AW-1:0] Rs_Addr,
  input  logic [AW-1:0] Rt_Addr,
  input  logic          Rs_Use,
  input  logic          Rt_Use,
  input  logic          Iss_En,
  input  logic [AW-1:0] Iss_Rd,
  input  logic          Wb_En,
  input  logic [AW-1:0] Wb_Addr,
  input  logic [DW-1:0] Wb_Data,
  output logic          Stall,
  output logic          Rd_Valid,
  output logic [DW-1:0] Rs_Data,
  output logic [DW-1:0] Rt_Data
);

  logic [DW-1:0]   regs [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  logic            wb_live;
  logic            iss_live;
  logic            haz_a;
  logic            haz_b;
  logic [DW-1:0]   rs_val;
  logic [DW-1:0]   rt_val;

  assign wb_live  = Wb_En  && (Wb_Addr != '0);
  assign iss_live = Iss_En && (Iss_Rd  != '0);

`ifdef REGFILE_WB_BYPASS_EN
  logic byp_a;
  logic byp_b;

  assign byp_a = wb_live && (Wb_Addr == Rs_Addr);
  assign byp_b = wb_live && (Wb_Addr == Rt_Addr);

  // Hazard check and read-value selection with writeback forwarding
  always_comb begin
    haz_a  = Rs_Use && busy[Rs_Addr] && !byp_a;
    haz_b  = Rt_Use && busy[Rt_Addr] && !byp_b;
    rs_val = byp_a ? Wb_Data : regs[Rs_Addr];
    rt_val = byp_b ? Wb_Data : regs[Rt_Addr];
  end
`else
  // Hazard check and read-value selection straight from the array
  always_comb begin
    haz_a  = Rs_Use && busy[Rs_Addr];
    haz_b  = Rt_Use && busy[Rt_Addr];
    rs_val = regs[Rs_Addr];
    rt_val = regs[Rt_Addr];
  end
`endif

  assign Stall = Rd_En && (haz_a || haz_b);

  // Next scoreboard: writeback clears, issue sets afterwards so a same-edge
  // issue to the written register leaves it pending for the newer producer
  always_comb begin
    busy_nxt = busy;
    if (wb_live)
      busy_nxt[Wb_Addr] = 1'b0;
    if (iss_live)
      busy_nxt[Iss_Rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge Clk) begin
    if (Rst)
      busy <= '0;
    else
      busy <= busy_nxt;
  end

  // Register array; entry 0 is never written so it stays at zero
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else if (wb_live) begin
      regs[Wb_Addr] <= Wb_Data;
    end
  end

  // Registered read ports; data holds when no fresh read is taken
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Rd_Valid <= 1'b0;
      Rs_Data  <= '0;
      Rt_Data  <= '0;
    end else if (Rd_En && !Stall) begin
      Rd_Valid <= 1'b1;
      Rs_Data  <= rs_val;
      Rt_Data  <= rt_val;
    end else begin
      Rd_Valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_sb_reader.sv
// Bench for regfile_sb_reader: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a reference model
// built from plain arrays.
module tb_regfile_sb_reader;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Rd_En;
  logic [4:0]  Rs_Addr;
  logic [4:0]  Rt_Addr;
  logic        Rs_Use;
  logic        Rt_Use;
  logic        Iss_En;
  logic [4:0]  Iss_Rd;
  logic        Wb_En;
  logic [4:0]  Wb_Addr;
  logic [31:0] Wb_Data;
  logic        Stall;
  logic        Rd_Valid;
  logic [31:0] Rs_Data;
  logic [31:0] Rt_Data;

  regfile_sb_reader #(.DW(32), .NREG(32)) dut (
    .Clk(Clk), .Rst(Rst), .Rd_En(Rd_En), .Rs_Addr(Rs_Addr), .Rt_Addr(Rt_Addr),
    .Rs_Use(Rs_Use), .Rt_Use(Rt_Use), .Iss_En(Iss_En), .Iss_Rd(Iss_Rd),
    .Wb_En(Wb_En), .Wb_Addr(Wb_Addr), .Wb_Data(Wb_Data), .Stall(Stall),
    .Rd_Valid(Rd_Valid), .Rs_Data(Rs_Data), .Rt_Data(Rt_Data)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_reg  [32];
  logic        m_busy [32];
  logic        m_valid;
  logic [31:0] m_rs;
  logic [31:0] m_rt;
  logic        stall_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic fwd(input logic [4:0] a);
`ifdef REGFILE_WB_BYPASS_EN
    return Wb_En && (Wb_Addr != 0) && (Wb_Addr == a);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic model_stall();
    logic ha, hb;
    ha = Rs_Use && m_busy[Rs_Addr] && !fwd(Rs_Addr);
    hb = Rt_Use && m_busy[Rt_Addr] && !fwd(Rt_Addr);
    return Rd_En && (ha || hb);
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (fwd(a)) return Wb_Data;
    return m_reg[a];
  endfunction

  // One clock: check Stall mid-cycle, advance the model, check registered outputs
  task automatic step();
    logic        n_valid;
    logic [31:0] n_rs, n_rt;
    logic        st;
    @(negedge Clk);
    st = model_stall();
    stall_seen = Stall;
    chk("stall", {31'b0, Stall}, {31'b0, st});
    n_valid = 1'b0;
    n_rs = m_rs;
    n_rt = m_rt;
    if (Rd_En && !st) begin
      n_valid = 1'b1;
      n_rs = model_read(Rs_Addr);
      n_rt = model_read(Rt_Addr);
    end
    @(posedge Clk);
    if (Rst) begin
      for (int i = 0; i < 32; i++) begin
        m_reg[i]  = 32'h0;
        m_busy[i] = 1'b0;
      end
      m_valid = 1'b0;
      m_rs = 32'h0;
      m_rt = 32'h0;
    end else begin
      m_valid = n_valid;
      m_rs = n_rs;
      m_rt = n_rt;
      if (Wb_En && Wb_Addr != 0) begin
        m_reg[Wb_Addr]  = Wb_Data;
        m_busy[Wb_Addr] = 1'b0;
      end
      if (Iss_En && Iss_Rd != 0)
        m_busy[Iss_Rd] = 1'b1;
    end
    #1;
    chk("rd_valid", {31'b0, Rd_Valid}, {31'b0, m_valid});
    chk("rs_data", Rs_Data, m_rs);
    chk("rt_data", Rt_Data, m_rt);
  endtask

  task automatic idle();
    Rst = 0; Rd_En = 0; Rs_Addr = 0; Rt_Addr = 0; Rs_Use = 0; Rt_Use = 0;
    Iss_En = 0; Iss_Rd = 0; Wb_En = 0; Wb_Addr = 0; Wb_Data = 0;
  endtask

  task automatic rd(input logic [4:0] rs, input logic [4:0] rt, input logic us, input logic ut);
    Rd_En = 1; Rs_Addr = rs; Rt_Addr = rt; Rs_Use = us; Rt_Use = ut;
  endtask

  initial begin
    int pick;
    for (int i = 0; i < 32; i++) begin
      m_reg[i] = 0;
      m_busy[i] = 0;
    end
    m_valid = 0; m_rs = 0; m_rt = 0; stall_seen = 0;
    idle();

    // reset
    Rst = 1; step(); step();
    idle();
    chk("reset_valid", {31'b0, Rd_Valid}, 32'd0);
    chk("reset_rs", Rs_Data, 32'h0);

    // first read after reset
    rd(5, 9, 1, 1); step();
    chk("lit_first_stall", {31'b0, stall_seen}, 32'd0);
    chk("lit_first_valid", {31'b0, Rd_Valid}, 32'd1);
    chk("lit_first_rt", Rt_Data, 32'h0);

    // write then read
    idle(); Wb_En = 1; Wb_Addr = 3; Wb_Data = 32'hDEADBEEF; step();
    idle(); rd(3, 0, 1, 1); step();
    chk("lit_rd3", Rs_Data, 32'hDEADBEEF);

    // r0 is immutable and never busy
    idle(); Wb_En = 1; Wb_Addr = 0; Wb_Data = 32'h12345678; step();
    idle(); rd(0, 3, 1, 1); Iss_En = 1; Iss_Rd = 0; step();
    chk("lit_r0", Rs_Data, 32'h0);
    idle(); rd(0, 0, 1, 1); step();
    chk("lit_r0_stall", {31'b0, stall_seen}, 32'd0);

    // RAW on r7
    idle(); Iss_En = 1; Iss_Rd = 7; step();
    idle(); rd(7, 0, 1, 0); step();
    chk("lit_raw_pend", {31'b0, stall_seen}, 32'd1);
    chk("lit_raw_pend_v", {31'b0, Rd_Valid}, 32'd0);
    Wb_En = 1; Wb_Addr = 7; Wb_Data = 32'hA5A5A5A5; step();
`ifdef REGFILE_WB_BYPASS_EN
    chk("lit_raw_wb_stall", {31'b0, stall_seen}, 32'd0);
    chk("lit_raw_wb_data", Rs_Data, 32'hA5A5A5A5);
`else
    chk("lit_raw_wb_stall", {31'b0, stall_seen}, 32'd1);
    chk("lit_raw_wb_v", {31'b0, Rd_Valid}, 32'd0);
`endif
    Wb_En = 0; step();
    chk("lit_raw_after_stall", {31'b0, stall_seen}, 32'd0);
    chk("lit_raw_after_data", Rs_Data, 32'hA5A5A5A5);
    chk("lit_raw_after_v", {31'b0, Rd_Valid}, 32'd1);

    // same-edge issue and writeback on r4
    idle(); Iss_En = 1; Iss_Rd = 4; Wb_En = 1; Wb_Addr = 4; Wb_Data = 32'h11; step();
    idle(); rd(0, 4, 0, 1); step();
    chk("lit_same_stall", {31'b0, stall_seen}, 32'd1);
    rd(0, 4, 0, 0); step();
    chk("lit_same_nouse", {31'b0, stall_seen}, 32'd0);
    chk("lit_same_data", Rt_Data, 32'h11);

    // reset drops pending state
    idle(); Iss_En = 1; Iss_Rd = 2; Wb_En = 1; Wb_Addr = 2; Wb_Data = 32'h55; step();
    idle(); Rst = 1; step();
    chk("lit_rst_valid", {31'b0, Rd_Valid}, 32'd0);
    idle(); rd(2, 2, 1, 1); step();
    chk("lit_rst_stall", {31'b0, stall_seen}, 32'd0);
    chk("lit_rst_data", Rs_Data, 32'h0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      idle();
      Rst = ($urandom_range(0, 299) == 0);
      Rd_En = $urandom_range(0, 3) != 0;
      Rs_Addr = 5'($urandom_range(0, 7));
      Rt_Addr = 5'($urandom_range(0, 7));
      Rs_Use = $urandom_range(0, 3) != 0;
      Rt_Use = $urandom_range(0, 3) != 0;
      Wb_En = $urandom_range(0, 1);
      Wb_Data = $urandom;
      Wb_Addr = 5'($urandom_range(0, 7));
      pick = $urandom_range(0, 7);
      for (int k = 0; k < 8; k++)
        if (m_busy[(pick + k) % 8] && $urandom_range(0, 1) == 1)
          Wb_Addr = 5'((pick + k) % 8);
      if (!model_stall() && $urandom_range(0, 2) == 0) begin
        Iss_En = 1;
        Iss_Rd = 5'($urandom_range(0, 7));
      end
      step();
    end

    idle(); step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_sb_reader.md
Name: regfile_sb_reader

Overview:
- 32 x 32-bit general-purpose register file for the pipelined core.
- Register read side (decode stage) with a pending-write scoreboard.
- Decode issues register reads through two source ports; writeback writes results.
- Scoreboard blocks reads of registers whose producing instruction has not yet written back.
- Read data is registered: one-cycle latency into the execute stage.

Parameters:
- DW, 32, data width of each register.
- NREG, 32, number of registers; address width is log2(NREG) = 5.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Rst  in  1  reset; synchronous, active-high.
- Rd_En  in  1  decode requests a read this cycle.
- Rs_Addr  in  5  source register A address.
- Rt_Addr  in  5  source register B address.
- Rs_Use  in  1  source A is actually consumed; gates scoreboard check.
- Rt_Use  in  1  source B is actually consumed; gates scoreboard check.
- Iss_En  in  1  instruction with a destination issues this cycle.
- Iss_Rd  in  5  destination register of the issuing instruction.
- Wb_En  in  1  writeback valid.
- Wb_Addr  in  5  writeback destination.
- Wb_Data  in  DW  writeback value.
- Stall  out  1  combinational; read blocked by a pending write.
- Rd_Valid  out  1  registered; Rs_Data/Rt_Data hold a fresh read.
- Rs_Data  out  DW  registered source A value.
- Rt_Data  out  DW  registered source B value.

Behaviour:
- Reset (Rst=1 at posedge, overrides all other inputs):
  - All registers cleared to 0.
  - All busy bits cleared.
  - Rd_Valid=0, Rs_Data=0, Rt_Data=0.
  - Stall is combinational; it reads 0 after reset because busy is clear.
- Register 0: always reads 0. Writes to it are ignored; it is never marked busy.
- Write:
  - At posedge, if Wb_En=1 and Wb_Addr!=0: reg[Wb_Addr]<=Wb_Data and busy[Wb_Addr]<=0.
- Issue:
  - At posedge, if Iss_En=1 and Iss_Rd!=0: busy[Iss_Rd]<=1.
  - Same edge, Iss_Rd==Wb_Addr: the register data is written, but busy ends at 1 (set wins; the newer producer is pending).
  - Issue does not depend on Stall; the issue stage asserts Iss_En only when Stall=0.
- Hazard check (combinational):
  - hazA = Rs_Use & busy[Rs_Addr]; hazB = Rt_Use & busy[Rt_Addr].
  - Stall = Rd_En & (hazA | hazB).
- Read (registered, latency 1):
  - At posedge, if Rd_En=1 and Stall=0: Rs_Data<=reg[Rs_Addr], Rt_Data<=reg[Rt_Addr], Rd_Valid<=1.
  - Otherwise: Rd_Valid<=0 and the data outputs hold their last value.
- Read of a register written on the same edge (no bypass):
  - The array value before the write is returned.
  - The scoreboard prevents this case for busy registers, because Stall=1 until busy clears.
- Unused source (Use=0): data is still read and returned, but never causes Stall.
- Reset mid-operation: all pending busy bits are lost; the pipeline is flushed by the same Rst.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined:
  - A source matching Wb_Addr (nonzero) while Wb_En=1 is treated as not busy in the hazard check.
  - Its captured data is Wb_Data instead of the array value.
  - Saves one stall cycle per RAW dependency.
- Not defined:
  - No bypass; the read stalls in the writeback cycle and succeeds on the following cycle.

Test Plan:
- Reset, then Rd_En=1, Rs=5, Rt=9 -> Stall=0; next cycle Rd_Valid=1, Rs_Data=0, Rt_Data=0.
- Wb_En=1, Wb_Addr=3, Wb_Data=0xDEADBEEF; next cycle Rd_En with Rs=3 -> Rs_Data=0xDEADBEEF after 1 cycle.
- Wb_Addr=0, Wb_Data=0x12345678; then read Rs=0 -> Rs_Data=0. Iss_Rd=0 never raises Stall.
- RAW with bypass disabled:
  - Iss_Rd=7; next cycle Rd_En, Rs=7, Rs_Use=1 -> Stall=1 while pending.
  - Writeback cycle (Wb 7 = 0xA5A5A5A5) -> Stall=1.
  - Following cycle -> Stall=0; Rs_Data=0xA5A5A5A5, Rd_Valid=1.
  - With REGFILE_WB_BYPASS_EN: Stall=0 in the writeback cycle; Rs_Data=0xA5A5A5A5 next edge.
- Same-edge Iss_Rd=4 and Wb_Addr=4 (0x11) -> reg[4]=0x11, busy[4]=1. A read of Rt=4 with Rt_Use=1 stalls; with Rt_Use=0 it returns 0x11 without Stall.
- Set busy[2] and reg[2]=0x55, assert Rst for one cycle -> busy clear, Rd_Valid=0; a read of 2 returns 0 with no Stall.
